// File: rtl/axi4_mem_master_pkg.sv
// Shared types and constants for the PicoRV32-style native-to-AXI4-lite
// memory master.
//   state_t   : controller states (idle, read address/data, write, write
//               response, one-cycle completion)
//   PROT_*    : AxPROT encodings for instruction fetches and data accesses
//   is_busy() : true in states where the watchdog counts
package axi4_mem_master_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RADDR = 3'd1,
    RDATA = 3'd2,
    WRITE = 3'd3,
    WRESP = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [2:0] PROT_INSN = 3'b100;
  localparam logic [2:0] PROT_DATA = 3'b000;

  // States where the controller is waiting on the AXI responder.
  function automatic logic is_busy(input state_t s);
    return (s == RADDR) || (s == RDATA) || (s == WRITE) || (s == WRESP);
  endfunction

endpackage

// File: rtl/axi4_mem_master.sv
// Native (picorv32 mem_*) request to single AXI4-lite transaction bridge.
// One request in flight at a time; completion is a one-cycle mem_ready pulse.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   mem_valid/instr/addr/wdata/wstrb   native request (wstrb==0 means read)
//   mem_ready, mem_rdata     completion pulse and last read data
//   mem_axi_aw*/w*/b*        AXI4-lite write channels
//   mem_axi_ar*/r*           AXI4-lite read channels
//   timeout_err, timeout_addr  sticky watchdog flag and first stuck address
// Every AXI output is a register; no valid depends combinationally on a ready.
module axi4_mem_master
  import axi4_mem_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_axi_awvalid,
  input  logic        mem_axi_awready,
  output logic [31:0] mem_axi_awaddr,
  output logic [2:0]  mem_axi_awprot,
  output logic        mem_axi_wvalid,
  input  logic        mem_axi_wready,
  output logic [31:0] mem_axi_wdata,
  output logic [3:0]  mem_axi_wstrb,
  input  logic        mem_axi_bvalid,
  output logic        mem_axi_bready,
  output logic        mem_axi_arvalid,
  input  logic        mem_axi_arready,
  output logic [31:0] mem_axi_araddr,
  output logic [2:0]  mem_axi_arprot,
  input  logic        mem_axi_rvalid,
  output logic        mem_axi_rready,
  input  logic [31:0] mem_axi_rdata,
  output logic        timeout_err,
  output logic [31:0] timeout_addr
);

  state_t      state_reg;
  logic [31:0] addr_reg;
  logic        aw_done_reg;
  logic        w_done_reg;
  logic [31:0] wdog_cnt_reg;

  logic aw_done_next;
  logic w_done_next;
  logic wdog_hit;

  always_comb begin
    // Flags include a handshake happening on this very edge, so AW and W
    // completing together move straight on to the response phase.
    aw_done_next = aw_done_reg | (mem_axi_awvalid & mem_axi_awready);
    w_done_next  = w_done_reg  | (mem_axi_wvalid  & mem_axi_wready);
    wdog_hit     = (TIMEOUT_CYCLES != 32'd0) && is_busy(state_reg) &&
                   (wdog_cnt_reg == TIMEOUT_CYCLES - 32'd1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      addr_reg        <= '0;
      aw_done_reg     <= 1'b0;
      w_done_reg      <= 1'b0;
      wdog_cnt_reg    <= '0;
      mem_ready       <= 1'b0;
      mem_rdata       <= '0;
      mem_axi_awvalid <= 1'b0;
      mem_axi_awaddr  <= '0;
      mem_axi_awprot  <= PROT_DATA;
      mem_axi_wvalid  <= 1'b0;
      mem_axi_wdata   <= '0;
      mem_axi_wstrb   <= '0;
      mem_axi_bready  <= 1'b0;
      mem_axi_arvalid <= 1'b0;
      mem_axi_araddr  <= '0;
      mem_axi_arprot  <= PROT_DATA;
      mem_axi_rready  <= 1'b0;
      timeout_err     <= 1'b0;
      timeout_addr    <= '0;
    end else begin
      mem_ready    <= 1'b0;
      // Counts while waiting on the responder; every transition below
      // overrides this with a clear.
      wdog_cnt_reg <= is_busy(state_reg) ? wdog_cnt_reg + 32'd1 : 32'd0;

      // The watchdog only reports; the transaction keeps waiting.
      if (wdog_hit) begin
        timeout_err <= 1'b1;
        if (!timeout_err) begin
          timeout_addr <= addr_reg;
        end
      end

      case (state_reg)
        IDLE: begin
          if (mem_valid) begin
            addr_reg     <= mem_addr;
            wdog_cnt_reg <= '0;
            if (mem_wstrb == 4'b0000) begin
              mem_axi_arvalid <= 1'b1;
              mem_axi_araddr  <= mem_addr;
              mem_axi_arprot  <= mem_instr ? PROT_INSN : PROT_DATA;
              state_reg       <= RADDR;
            end else begin
              mem_axi_awvalid <= 1'b1;
              mem_axi_awaddr  <= mem_addr;
              mem_axi_awprot  <= PROT_DATA;
              mem_axi_wvalid  <= 1'b1;
              mem_axi_wdata   <= mem_wdata;
              mem_axi_wstrb   <= mem_wstrb;
              aw_done_reg     <= 1'b0;
              w_done_reg      <= 1'b0;
              state_reg       <= WRITE;
            end
          end
        end

        RADDR: begin
          if (mem_axi_arvalid && mem_axi_arready) begin
            mem_axi_arvalid <= 1'b0;
            mem_axi_rready  <= 1'b1;
            wdog_cnt_reg    <= '0;
            state_reg       <= RDATA;
          end
        end

        RDATA: begin
          if (mem_axi_rvalid && mem_axi_rready) begin
            mem_rdata      <= mem_axi_rdata;
            mem_ready      <= 1'b1;
            mem_axi_rready <= 1'b0;
            wdog_cnt_reg   <= '0;
            state_reg      <= DONE;
          end
        end

        WRITE: begin
          if (mem_axi_awvalid && mem_axi_awready) begin
            mem_axi_awvalid <= 1'b0;
          end
          if (mem_axi_wvalid && mem_axi_wready) begin
            mem_axi_wvalid <= 1'b0;
          end
          aw_done_reg <= aw_done_next;
          w_done_reg  <= w_done_next;
          if (aw_done_next && w_done_next) begin
            mem_axi_bready <= 1'b1;
            wdog_cnt_reg   <= '0;
            state_reg      <= WRESP;
          end
        end

        WRESP: begin
          if (mem_axi_bvalid && mem_axi_bready) begin
            mem_ready      <= 1'b1;
            mem_axi_bready <= 1'b0;
            wdog_cnt_reg   <= '0;
            state_reg      <= DONE;
          end
        end

        DONE: begin
          // mem_valid is still high here (requester drops it after
          // mem_ready), so it must not start a new transaction.
          wdog_cnt_reg <= '0;
          state_reg    <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_mem_master.sv
// Self-checking bench for axi4_mem_master: AXI4-lite RAM responder with
// optional random stalls, scoreboard of expected completions, channel
// stability monitor and directed corner cases.
`timescale 1ns/1ps
module tb_axi4_mem_master;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_valid = 1'b0;
  logic        mem_instr = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_axi_awvalid, mem_axi_awready;
  logic [31:0] mem_axi_awaddr;
  logic [2:0]  mem_axi_awprot;
  logic        mem_axi_wvalid, mem_axi_wready;
  logic [31:0] mem_axi_wdata;
  logic [3:0]  mem_axi_wstrb;
  logic        mem_axi_bvalid, mem_axi_bready;
  logic        mem_axi_arvalid, mem_axi_arready;
  logic [31:0] mem_axi_araddr;
  logic [2:0]  mem_axi_arprot;
  logic        mem_axi_rvalid, mem_axi_rready;
  logic [31:0] mem_axi_rdata;
  logic        timeout_err;
  logic [31:0] timeout_addr;

  axi4_mem_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .mem_axi_awvalid(mem_axi_awvalid), .mem_axi_awready(mem_axi_awready),
    .mem_axi_awaddr(mem_axi_awaddr), .mem_axi_awprot(mem_axi_awprot),
    .mem_axi_wvalid(mem_axi_wvalid), .mem_axi_wready(mem_axi_wready),
    .mem_axi_wdata(mem_axi_wdata), .mem_axi_wstrb(mem_axi_wstrb),
    .mem_axi_bvalid(mem_axi_bvalid), .mem_axi_bready(mem_axi_bready),
    .mem_axi_arvalid(mem_axi_arvalid), .mem_axi_arready(mem_axi_arready),
    .mem_axi_araddr(mem_axi_araddr), .mem_axi_arprot(mem_axi_arprot),
    .mem_axi_rvalid(mem_axi_rvalid), .mem_axi_rready(mem_axi_rready),
    .mem_axi_rdata(mem_axi_rdata),
    .timeout_err(timeout_err), .timeout_addr(timeout_addr)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int unsigned i);
    if (i == 32'h40) return 32'h1234_5678;
    return (32'hC0DE_0000 | i) ^ (i << 20);
  endfunction

  // ---------------- responder ----------------
  logic [31:0] smem [0:255];
  logic [31:0] ref_mem [0:255];
  int unsigned stall_pct = 0;
  logic ar_never = 1'b0, hold_aw = 1'b0, r_hold = 1'b0;
  logic ar_rnd = 1'b1, aw_rnd = 1'b1, w_rnd = 1'b1, r_rnd = 1'b1, b_rnd = 1'b1;
  logic rpend, bpend, aw_got, w_got;
  logic [7:0]  r_idx;
  logic [31:0] aw_addr_s, w_data_s;
  logic [3:0]  w_strb_s;
  int aw_xfers = 0, w_xfers = 0;
  logic [31:0] last_araddr = '0;
  logic [2:0]  last_arprot = '0;
  logic aw_hs, w_hs, ar_hs, wr_fire, r_ok, b_ok;
  logic [31:0] wr_addr, wr_data, wr_word;
  logic [3:0]  wr_strb;

  always @(posedge clk) begin
    ar_rnd <= ($urandom_range(0, 99) >= stall_pct);
    aw_rnd <= ($urandom_range(0, 99) >= stall_pct);
    w_rnd  <= ($urandom_range(0, 99) >= stall_pct);
    r_rnd  <= ($urandom_range(0, 99) >= stall_pct);
    b_rnd  <= ($urandom_range(0, 99) >= stall_pct);
  end

  assign mem_axi_arready = !ar_never && ar_rnd;
  assign mem_axi_awready = !hold_aw && aw_rnd;
  assign mem_axi_wready  = w_rnd;

  always_comb begin
    aw_hs   = mem_axi_awvalid && mem_axi_awready;
    w_hs    = mem_axi_wvalid && mem_axi_wready;
    ar_hs   = mem_axi_arvalid && mem_axi_arready;
    r_ok    = !r_hold && r_rnd;
    b_ok    = b_rnd;
    wr_addr = aw_hs ? mem_axi_awaddr : aw_addr_s;
    wr_data = w_hs ? mem_axi_wdata : w_data_s;
    wr_strb = w_hs ? mem_axi_wstrb : w_strb_s;
    wr_fire = (aw_got || aw_hs) && (w_got || w_hs);
    wr_word = smem[wr_addr[9:2]];
    for (int b = 0; b < 4; b++)
      if (wr_strb[b]) wr_word[8*b +: 8] = wr_data[8*b +: 8];
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_axi_rvalid <= 1'b0;
      mem_axi_rdata  <= '0;
      mem_axi_bvalid <= 1'b0;
      rpend <= 1'b0; bpend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
      r_idx <= '0; aw_addr_s <= '0; w_data_s <= '0; w_strb_s <= '0;
      for (int i = 0; i < 256; i++) smem[i] <= init_word(i);
    end else begin
      if (aw_hs) begin aw_addr_s <= mem_axi_awaddr; aw_xfers <= aw_xfers + 1; end
      if (w_hs) begin
        w_data_s <= mem_axi_wdata; w_strb_s <= mem_axi_wstrb; w_xfers <= w_xfers + 1;
      end
      if (wr_fire) begin
        smem[wr_addr[9:2]] <= wr_word;
        aw_got <= 1'b0; w_got <= 1'b0;
        if (b_ok) mem_axi_bvalid <= 1'b1; else bpend <= 1'b1;
      end else begin
        if (aw_hs) aw_got <= 1'b1;
        if (w_hs) w_got <= 1'b1;
      end
      if (bpend && b_ok) begin mem_axi_bvalid <= 1'b1; bpend <= 1'b0; end
      if (mem_axi_bvalid && mem_axi_bready) mem_axi_bvalid <= 1'b0;

      if (ar_hs) begin
        last_araddr <= mem_axi_araddr;
        last_arprot <= mem_axi_arprot;
        if (r_ok) begin
          mem_axi_rvalid <= 1'b1; mem_axi_rdata <= smem[mem_axi_araddr[9:2]];
        end else begin
          rpend <= 1'b1; r_idx <= mem_axi_araddr[9:2];
        end
      end
      if (rpend && r_ok) begin
        mem_axi_rvalid <= 1'b1; mem_axi_rdata <= smem[r_idx]; rpend <= 1'b0;
      end
      if (mem_axi_rvalid && mem_axi_rready) mem_axi_rvalid <= 1'b0;
    end
  end

  // ---------------- stability / pulse monitor ----------------
  logic p_arv = 1'b0, p_arr = 1'b0, p_awv = 1'b0, p_awr = 1'b0, p_wv = 1'b0, p_wr = 1'b0;
  logic [31:0] p_araddr = '0, p_awaddr = '0, p_wdata = '0;
  logic [2:0]  p_arprot = '0, p_awprot = '0;
  logic [3:0]  p_wstrb = '0;
  logic ar_bad, aw_bad, w_bad, both_bad;
  int stab_viol = 0;
  int ready_pulses = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    ar_bad = p_arv && !p_arr && !(mem_axi_arvalid && mem_axi_araddr == p_araddr &&
                                  mem_axi_arprot == p_arprot);
    aw_bad = p_awv && !p_awr && !(mem_axi_awvalid && mem_axi_awaddr == p_awaddr &&
                                  mem_axi_awprot == p_awprot);
    w_bad  = p_wv && !p_wr && !(mem_axi_wvalid && mem_axi_wdata == p_wdata &&
                                mem_axi_wstrb == p_wstrb);
    both_bad = mem_axi_arvalid && (mem_axi_awvalid || mem_axi_wvalid);
  end

  always @(negedge clk) begin
    ready_pulses <= ready_pulses + int'(mem_ready);
    if (rst) begin
      p_arv <= 1'b0; p_awv <= 1'b0; p_wv <= 1'b0;
    end else begin
      stab_viol <= stab_viol + int'(ar_bad) + int'(aw_bad) + int'(w_bad) + int'(both_bad);
      p_arv <= mem_axi_arvalid; p_arr <= mem_axi_arready;
      p_araddr <= mem_axi_araddr; p_arprot <= mem_axi_arprot;
      p_awv <= mem_axi_awvalid; p_awr <= mem_axi_awready;
      p_awaddr <= mem_axi_awaddr; p_awprot <= mem_axi_awprot;
      p_wv <= mem_axi_wvalid; p_wr <= mem_axi_wready;
      p_wdata <= mem_axi_wdata; p_wstrb <= mem_axi_wstrb;
    end
  end

  // ---------------- scoreboard and request driver ----------------
  typedef struct {
    logic        is_rd;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];
  int start_cyc = 0;
  int last_lat = 0;
  int n_done = 0;
  int n_writes = 0;

  task automatic init_ref();
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
  endtask

  task automatic start_req(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic ins);
    exp_t e;
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = s; mem_instr = ins;
    e.is_rd = (s == 4'b0000);
    e.addr  = a;
    e.data  = ref_mem[a[9:2]];
    if (s != 4'b0000) begin
      n_writes++;
      for (int b = 0; b < 4; b++)
        if (s[b]) ref_mem[a[9:2]][8*b +: 8] = d[8*b +: 8];
    end
    sb.push_back(e);
    start_cyc = cyc;
  endtask

  task automatic wait_done(input int budget, input bit drop_early, input string tag);
    int n;
    bit seen;
    exp_t e;
    n = 0; seen = 1'b0;
    while (n < budget && !seen) begin
      @(negedge clk);
      n++;
      if (mem_ready) seen = 1'b1;
      else if (drop_early && n == 1) mem_valid = 1'b0;
    end
    if (!seen) begin
      check_eq({tag, "_ready_timeout"}, 32'd0, 32'd1);
      mem_valid = 1'b0;
      if (sb.size() != 0) void'(sb.pop_front());
    end else begin
      last_lat = cyc - start_cyc + 1;
      mem_valid = 1'b0;
      n_done++;
      if (sb.size() == 0) begin
        check_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        if (e.is_rd) check_eq({tag, "_rdata"}, mem_rdata, e.data);
        $display("[TB] %s %s addr=0x%08h data=0x%08h lat=%0d", tag,
                 e.is_rd ? "RD" : "WR", e.addr, e.is_rd ? mem_rdata : mem_wdata, last_lat);
      end
      @(negedge clk);
      check_eq({tag, "_ready_1cyc"}, 32'(mem_ready), 32'd0);
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int k;
    int aw0, w0;
    logic [31:0] a, d;
    logic [3:0]  s;
    init_ref();
    repeat (3) @(negedge clk);
    check_eq("rst_ctrl", 32'({mem_ready, mem_axi_arvalid, mem_axi_rready, mem_axi_awvalid,
                              mem_axi_wvalid, mem_axi_bready, timeout_err}), 32'd0);
    check_eq("rst_rdata", mem_rdata, 32'd0);
    check_eq("rst_taddr", timeout_addr, 32'd0);
    rst = 1'b0;

    // 1. zero-wait instruction read
    start_req(32'h100, 32'd0, 4'b0000, 1'b1);
    wait_done(20, 1'b0, "rd_zero_wait");
    check_eq("rd_zero_wait_lat", 32'(last_lat), 32'd4);
    check_eq("rd_zero_wait_araddr", last_araddr, 32'h100);
    check_eq("rd_zero_wait_arprot", 32'(last_arprot), 32'd4);

    // 2. W accepted 3 cycles before AW
    aw0 = aw_xfers; w0 = w_xfers;
    hold_aw = 1'b1;
    start_req(32'h204, 32'hAABB_CCDD, 4'b0101, 1'b0);
    k = 0;
    while (k < 10) begin
      @(negedge clk); k++;
      if (!mem_axi_wvalid) break;
    end
    check_eq("wfirst_wvalid", 32'(mem_axi_wvalid), 32'd0);
    check_eq("wfirst_awvalid", 32'(mem_axi_awvalid), 32'd1);
    repeat (3) begin
      @(negedge clk);
      check_eq("wfirst_bready_hold", 32'(mem_axi_bready), 32'd0);
    end
    hold_aw = 1'b0;
    wait_done(20, 1'b0, "wr_w_first");
    check_eq("wfirst_mem", smem[8'h81], (init_word(32'h81) & 32'hFF00_FF00) | 32'h00BB_00DD);
    check_eq("wfirst_aw_cnt", 32'(aw_xfers - aw0), 32'd1);
    check_eq("wfirst_w_cnt", 32'(w_xfers - w0), 32'd1);
    start_req(32'h204, 32'd0, 4'b0000, 1'b0);
    wait_done(20, 1'b0, "rd_back_204");

    // 3. AW and W handshake on the same edge
    aw0 = aw_xfers; w0 = w_xfers;
    start_req(32'h208, 32'h1122_3344, 4'b1111, 1'b0);
    @(negedge clk);
    check_eq("same_both_valid", 32'({mem_axi_awvalid, mem_axi_wvalid}), 32'd3);
    @(negedge clk);
    check_eq("same_bready", 32'(mem_axi_bready), 32'd1);
    check_eq("same_valids_low", 32'({mem_axi_awvalid, mem_axi_wvalid}), 32'd0);
    wait_done(20, 1'b0, "wr_same_cycle");
    check_eq("same_aw_cnt", 32'(aw_xfers - aw0), 32'd1);
    check_eq("same_w_cnt", 32'(w_xfers - w0), 32'd1);
    check_eq("same_mem", smem[8'h82], 32'h1122_3344);

    // 4. watchdog: arready never comes
    ar_never = 1'b1;
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = 32'h300; mem_wstrb = 4'b0000; mem_instr = 1'b0;
    repeat (16) @(negedge clk);
    check_eq("wdog_not_yet", 32'(timeout_err), 32'd0);
    @(negedge clk);
    check_eq("wdog_err", 32'(timeout_err), 32'd1);
    check_eq("wdog_addr", timeout_addr, 32'h300);
    repeat (3) @(negedge clk);
    check_eq("wdog_arvalid_held", 32'(mem_axi_arvalid), 32'd1);
    check_eq("wdog_araddr_held", mem_axi_araddr, 32'h300);
    $display("[TB] wdog RD addr=0x%08h timeout_err=%0d", 32'h300, timeout_err);
    #2 rst = 1'b1;
    #1 check_eq("wdog_rst_async", 32'({mem_axi_arvalid, timeout_err}), 32'd0);
    mem_valid = 1'b0; ar_never = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    init_ref();

    // 5. reset while waiting in RDATA
    start_req(32'h40C, 32'd0, 4'b0000, 1'b0);
    void'(sb.pop_front());
    r_hold = 1'b1;
    k = 0;
    while (k < 10 && !mem_axi_rready) begin @(negedge clk); k++; end
    check_eq("rstrd_in_rdata", 32'(mem_axi_rready), 32'd1);
    #2 rst = 1'b1;
    #1 check_eq("rstrd_async", 32'({mem_ready, mem_axi_arvalid, mem_axi_rready,
                                     mem_axi_awvalid, mem_axi_wvalid, mem_axi_bready}), 32'd0);
    check_eq("rstrd_rdata_clr", mem_rdata, 32'd0);
    mem_valid = 1'b0; r_hold = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    init_ref();
    $display("[TB] rst RD addr=0x%08h abandoned", 32'h40C);
    start_req(32'h40C, 32'd0, 4'b0000, 1'b0);
    wait_done(20, 1'b0, "rd_after_rst");

    // 6. random mixed traffic with stalls
    stall_pct = 30;
    for (int i = 0; i < 200; i++) begin
      a = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      d = $urandom;
      s = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      start_req(a, d, s, 1'($urandom_range(0, 1)));
      wait_done(200, 1'($urandom_range(0, 1)), "rand");
    end
    stall_pct = 0;
    repeat (4) @(negedge clk);

    check_eq("end_ready_pulses", 32'(ready_pulses), 32'(n_done));
    check_eq("end_stability", 32'(stab_viol), 32'd0);
    check_eq("end_no_timeout", 32'(timeout_err), 32'd0);
    check_eq("end_sb_empty", 32'(sb.size()), 32'd0);
    check_eq("end_aw_vs_w", 32'(aw_xfers), 32'(w_xfers));
    check_eq("end_writes", 32'(w_xfers), 32'(n_writes));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: got 0x%08h expected 0x%08h", cyc, 0);
    $fatal(1, "global timeout");
  end

endmodule
